// File: rtl/cache_pkg.sv
// Shared state encoding, geometry constants and word-select helper for the
// direct-mapped read-only cache.
package cache_pkg;

  localparam int C_ADDR_W        = 15;
  localparam int C_INDEX_W       = 8;
  localparam int C_OFFSET_W      = 2;
  localparam int C_TAG_W         = C_ADDR_W - C_INDEX_W - C_OFFSET_W;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 1 << C_OFFSET_W;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int NUM_LINES       = 1 << C_INDEX_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    FETCH   = 3'd2,
    FILL    = 3'd3,
    RESPOND = 3'd4
  } state_t;

  // Word k of a block sits at bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0]    blk,
                                                    input logic [C_OFFSET_W-1:0] off);
    return blk[int'(off)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_if.sv
// CPU load-path and memory block-read signals of the cache controller.
// master = requester/memory side, slave = the cache controller.
interface cache_if #(
  parameter int ADDR_W  = cache_pkg::C_ADDR_W,
  parameter int WORD_W  = cache_pkg::WORD_W,
  parameter int BLOCK_W = cache_pkg::BLOCK_W
) ();

  logic               cpu_req;
  logic [ADDR_W-1:0]  cpu_address;
  logic               cpu_ready;
  logic               cpu_hit;
  logic [WORD_W-1:0]  cpu_data;
  logic               mem_read;
  logic [ADDR_W-1:0]  mem_address;
  logic               mem_data_ready;
  logic [BLOCK_W-1:0] mem_data_block;

  modport master (
    output cpu_req, cpu_address, mem_data_ready, mem_data_block,
    input  cpu_ready, cpu_hit, cpu_data, mem_read, mem_address
  );

  modport slave (
    input  cpu_req, cpu_address, mem_data_ready, mem_data_block,
    output cpu_ready, cpu_hit, cpu_data, mem_read, mem_address
  );

endinterface

// File: rtl/cache_array.sv
// Valid/tag/data store: combinational read by index, one synchronous write
// port, and a one-cycle synchronous clear of every valid bit.
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = C_INDEX_W,
  parameter int TAG_W   = C_TAG_W,
  parameter int BLK_W   = BLOCK_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLK_W-1:0]   rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLK_W-1:0]   wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [BLK_W-1:0] data_mem [LINES];

  // Next valid vector: a fill marks its line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only reset state of the store.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays are plain storage without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped read-only cache controller (256 lines x 4 words).
// Optional hit/access statistics outputs with `define CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W   = C_ADDR_W,
  parameter int INDEX_W  = C_INDEX_W,
  parameter int OFFSET_W = C_OFFSET_W,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic        clk,
  input  logic        rst,
  cache_if.slave      bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] access_count,
  output logic [31:0] hit_count
`endif
);

  localparam int BLK_W = WORD_W << OFFSET_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                cpu_hit_q, cpu_hit_d;
  logic [WORD_W-1:0]   cpu_data_q, cpu_data_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic                first_fetch_q, first_fetch_d;
  logic                fill_we;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_off;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [BLK_W-1:0]    rd_data;

  assign addr_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign addr_index = addr_q[OFFSET_W +: INDEX_W];
  assign addr_off   = addr_q[OFFSET_W-1:0];

  cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .BLK_W   (BLK_W)
  ) u_array (
    .clk      (clk),
    .clr      (rst),
    .rd_index (addr_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_we),
    .wr_index (addr_index),
    .wr_tag   (addr_tag),
    .wr_data  (bus.mem_data_block)
  );

  // Next-state and registered-output logic of the lookup/refill FSM.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cpu_ready_d   = 1'b0;
    cpu_hit_d     = cpu_hit_q;
    cpu_data_d    = cpu_data_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    first_fetch_d = 1'b0;
    fill_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_address;
          state_d = COMPARE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (rd_valid && (rd_tag == addr_tag)) begin
          cpu_hit_d   = 1'b1;
          cpu_data_d  = select_word(rd_data, addr_off);
          cpu_ready_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          mem_read_d    = 1'b1;
          mem_address_d = {addr_tag, addr_index, {OFFSET_W{1'b0}}};
          first_fetch_d = 1'b1;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        // A ready still high from the previous transfer is masked for one cycle.
        if (!first_fetch_q && bus.mem_data_ready) begin
          state_d = FILL;
        end else begin
          state_d = FETCH;
        end
      end
      FILL: begin
        mem_read_d  = 1'b0;
        fill_we     = 1'b1;
        cpu_hit_d   = 1'b0;
        cpu_data_d  = select_word(bus.mem_data_block, addr_off);
        cpu_ready_d = 1'b1;
        state_d     = RESPOND;
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cpu_ready_q   <= 1'b0;
      cpu_hit_q     <= 1'b0;
      cpu_data_q    <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      first_fetch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_hit_q     <= cpu_hit_d;
      cpu_data_q    <= cpu_data_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      first_fetch_q <= first_fetch_d;
    end
  end

  assign bus.cpu_ready   = cpu_ready_q;
  assign bus.cpu_hit     = cpu_hit_q;
  assign bus.cpu_data    = cpu_data_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = mem_address_q;

`ifdef CACHE_STATS_EN
  logic [31:0] access_count_q, access_count_d;
  logic [31:0] hit_count_q, hit_count_d;

  // Counters advance once per RESPOND cycle and wrap naturally.
  always_comb begin
    access_count_d = access_count_q;
    hit_count_d    = hit_count_q;
    if (state_q == RESPOND) begin
      access_count_d = access_count_q + 32'd1;
      if (cpu_hit_q) begin
        hit_count_d = hit_count_q + 32'd1;
      end else begin
        hit_count_d = hit_count_q;
      end
    end else begin
      access_count_d = access_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      access_count_q <= 32'd0;
      hit_count_q    <= 32'd0;
    end else begin
      access_count_q <= access_count_d;
      hit_count_q    <= hit_count_d;
    end
  end

  assign access_count = access_count_q;
  assign hit_count    = hit_count_q;
`endif

endmodule
